// File: rtl/nsdp_pkg.sv
// rtl/nsdp_pkg.sv - shared constants, state enum and fill-pattern helper for the NSDP checker
package nsdp_pkg;

  localparam int ERR_BAD_FDATA  = 0;
  localparam int ERR_BAD_TADDR  = 1;
  localparam int ERR_SHORT_PKT  = 2;
  localparam int ERR_LONG_PKT   = 3;
  localparam int ERR_W          = 15;
  localparam int BEAT_W         = 512;
  localparam int WORDS_PER_BEAT = 16;
  localparam int BEAT_BYTES     = 64;

  typedef enum logic [1:0] {HDR, DATA, ERROR} state_t;

  // Word k sits at the top of the beat first; all 16 compares are independent.
  function automatic logic fill_mismatch(input logic [BEAT_W-1:0] tdata, input logic [31:0] base);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < WORDS_PER_BEAT; k++) begin
      if (tdata[BEAT_W-1-32*k -: 32] != base + 32'(k)) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/nsdp_activity_timer.sv
// rtl/nsdp_activity_timer.sv - down-counter that holds active high for ACTIVE_TIMEOUT idle cycles after a beat
module nsdp_activity_timer #(
  parameter int ACTIVE_TIMEOUT = 250_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic beat,
  input  logic clear,
  output logic active
);

  localparam int CNT_W = $clog2(ACTIVE_TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // active drops on the same edge the count reaches zero.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      count  <= '0;
      active <= 1'b0;
    end else if (beat) begin
      count  <= CNT_W'(ACTIVE_TIMEOUT);
      active <= 1'b1;
    end else if (count != '0) begin
      count  <= count - CNT_W'(1);
      active <= count > CNT_W'(1);
    end
  end

endmodule

// File: rtl/nsdp_stream_checker.sv
// rtl/nsdp_stream_checker.sv - per-channel NSDP packet sequence/fill checker with error snapshot
module nsdp_stream_checker
  import nsdp_pkg::*;
#(
  parameter int          DATA_BEATS     = 64,
  parameter logic [63:0] TADDR_BASE     = 64'h0,
  parameter logic [63:0] TADDR_SPAN     = 64'h1_0000_0000,
  parameter logic [31:0] FDATA_INIT     = 32'h0,
  parameter int          ACTIVE_TIMEOUT = 250_000_000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic [BEAT_W-1:0] axis_tdata,
  input  logic              axis_tvalid,
  input  logic              axis_tlast,
  output logic              axis_tready,
  output logic              eth_active,
  output logic              status,
  output logic [ERR_W-1:0]  error,
  output logic [BEAT_W-1:0] error_data,
  output logic [31:0]       expected_fdata,
  output logic [63:0]       expected_taddr,
  output logic [63:0]       packets_rcvd
);

  localparam int IDX_W = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] beat_idx;
  logic [ERR_W-1:0] err_nxt;
  logic             beat;
  logic             last_beat;
  logic [63:0]      taddr_inc;

  assign axis_tready = 1'b1;
  assign beat        = axis_tvalid & ~clear;
  assign last_beat   = beat_idx == IDX_W'(DATA_BEATS - 1);
  assign taddr_inc   = expected_taddr + 64'(DATA_BEATS * BEAT_BYTES);

  always_comb begin
    state_nxt = state;
    err_nxt   = '0;
    if (beat) begin
      case (state)
        HDR: begin
          if (axis_tdata[63:0] != expected_taddr) err_nxt[ERR_BAD_TADDR] = 1'b1;
          if (axis_tlast) err_nxt[ERR_SHORT_PKT] = 1'b1;
          state_nxt = DATA;
        end
        DATA: begin
          if (fill_mismatch(axis_tdata, expected_fdata)) err_nxt[ERR_BAD_FDATA] = 1'b1;
          if (axis_tlast && !last_beat) err_nxt[ERR_SHORT_PKT] = 1'b1;
          if (!axis_tlast && last_beat) err_nxt[ERR_LONG_PKT] = 1'b1;
          if (last_beat) state_nxt = HDR;
        end
        default: ;
      endcase
      if (err_nxt != '0) state_nxt = ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) state <= HDR;
    else                  state <= state_nxt;
  end

  // Expected values only advance on clean beats, so an error freezes the pre-beat view.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      beat_idx       <= '0;
      error          <= '0;
      error_data     <= '0;
      status         <= 1'b0;
      packets_rcvd   <= '0;
      expected_fdata <= FDATA_INIT;
      expected_taddr <= TADDR_BASE;
    end else if (beat) begin
      if (axis_tlast) packets_rcvd <= packets_rcvd + 64'd1;
      if (err_nxt != '0) begin
        error      <= error | err_nxt;
        error_data <= axis_tdata;
        status     <= 1'b1;
      end else if (state == HDR) begin
        beat_idx <= '0;
      end else if (state == DATA) begin
        expected_fdata <= expected_fdata + 32'd16;
        beat_idx       <= beat_idx + IDX_W'(1);
        if (last_beat)
          expected_taddr <= (taddr_inc == TADDR_BASE + TADDR_SPAN) ? TADDR_BASE : taddr_inc;
      end
    end
  end

  nsdp_activity_timer #(
    .ACTIVE_TIMEOUT(ACTIVE_TIMEOUT)
  ) u_activity_timer (
    .clk   (clk),
    .resetn(resetn),
    .beat  (beat),
    .clear (clear),
    .active(eth_active)
  );

endmodule

// File: doc/nsdp_stream_checker.md
# nsdp_stream_checker

Per-channel NSDP packet checker. It sinks one 512-bit AXI-Stream of NSDP packets, verifies the target-address sequence and the fill-data pattern, and counts packets. On the first failure it freezes a snapshot of the failing beat. Two instances (ch0, ch1) feed the checker's AXI register reporter through their eth_active, status, error, error_data, expected_fdata, expected_taddr and packets_rcvd outputs.

## Interface
Parameters:
- DATA_BEATS, 64: data beats per packet after the header beat.
- TADDR_BASE, 64'h0: first expected target address.
- TADDR_SPAN, 64'h1_0000_0000: address window size; multiple of DATA_BEATS*64.
- FDATA_INIT, 32'h0: first expected fill word.
- ACTIVE_TIMEOUT, 250_000_000: idle cycles before eth_active drops.

Ports:
- clk, in, 1: clock.
- resetn, in, 1: reset, synchronous, active-low.
- clear, in, 1: one-cycle pulse; restarts checking and zeroes counters.
- axis_tdata, in, 512: stream data.
- axis_tvalid, in, 1: stream valid.
- axis_tlast, in, 1: end of packet.
- axis_tready, out, 1: constant 1 (pure sink).
- eth_active, out, 1: a beat was accepted within the last ACTIVE_TIMEOUT cycles.
- status, out, 1: 1 = error latched.
- error, out, 15: latched error bits.
- error_data, out, 512: tdata of the first failing beat.
- expected_fdata, out, 32: current expected fill word; frozen at error.
- expected_taddr, out, 64: current expected target address; frozen at error.
- packets_rcvd, out, 64: count of packets whose tlast beat was accepted.

## Operation
- A beat is accepted when axis_tvalid=1; tready is always 1.
- **State HDR**
  - Header beat: address = tdata[63:0], compared with expected_taddr; mismatch sets bit 1 (BAD_TADDR).
  - tlast on the header sets bit 2 (SHORT_PKT).
  - No error: go to DATA and clear the beat index.
- **State DATA**
  - Word k (k=0..15) is tdata[511-32k -: 32] and must equal expected_fdata+k (mod 2^32). Any mismatch sets bit 0 (BAD_FDATA).
  - After each beat, expected_fdata += 16 (mod 2^32).
  - tlast before beat DATA_BEATS-1 sets bit 2. No tlast on beat DATA_BEATS-1 sets bit 3 (LONG_PKT).
  - On the final clean beat: expected_taddr += DATA_BEATS*64; if the result equals TADDR_BASE+TADDR_SPAN, it wraps to TADDR_BASE. Then go to HDR.
- **Any error bit set on a beat**
  - All bits detected on that beat are ORed into error, simultaneously.
  - error_data <= tdata; status <= 1; go to ERROR.
  - expected_fdata and expected_taddr keep their pre-beat values.
- **State ERROR**
  - Beats are consumed and no further checks are made.
  - packets_rcvd still counts every accepted tlast beat.
  - Exit only via clear or reset.
- packets_rcvd increments on every accepted tlast beat in any state, including erroring beats. It wraps mod 2^64.
- error bits 14:4 are reserved and always 0.
- **clear, or resetn=0**
  - State <= HDR; error, error_data, status, packets_rcvd <= 0.
  - expected_fdata <= FDATA_INIT; expected_taddr <= TADDR_BASE; activity timer expires (eth_active <= 0).
- **clear coincident with a beat:** clear wins and the beat is ignored entirely.

## Timing
- All outputs are registered and reflect an accepted beat on the following cycle.
- Reset values: axis_tready=1; every other output is 0, except expected_fdata=FDATA_INIT and expected_taddr=TADDR_BASE.
- Reset mid-packet aborts the packet; the next accepted beat is treated as a header.
- eth_active:
  - Goes to 1 the cycle after any accepted beat.
  - Goes to 0 after ACTIVE_TIMEOUT consecutive cycles with no accepted beat.
  - The timer reloads on every beat.
- Throughput: one beat per cycle sustained; back-to-back packets need no idle cycle.
- Comparisons are single-cycle. The 16 word compares run in parallel against expected_fdata+k computed from the current register.

## Structure
- Shared package nsdp_pkg holds:
  - ERR_BAD_FDATA=0, ERR_BAD_TADDR=1, ERR_SHORT_PKT=2, ERR_LONG_PKT=3;
  - ERR_W=15, BEAT_W=512, WORDS_PER_BEAT=16, BEAT_BYTES=64;
  - the state enum {HDR, DATA, ERROR}.
- One sub-module, nsdp_activity_timer (parameter ACTIVE_TIMEOUT; inputs beat and clear; output active), isolates the down-counter.

## Test plan
- **Clean run:** DATA_BEATS=4, three well-formed packets starting at taddr 0 with fill 0 -> packets_rcvd=3, status=0, expected_taddr=0x300, expected_fdata=192, eth_active=1.
- **Fill error:** second data beat of packet 1, word 5 = 0xDEADBEEF -> error=0x0001, error_data equals that beat, expected_fdata=16 (frozen); following packets still count.
- **Address error plus short packet:** header taddr=0x40 with tlast=1 -> error=0x0006 in a single cycle, status=1.
- **Length errors:**
  - No tlast on beat 3 -> error=0x0008.
  - A separate run with tlast on data beat 1 -> error=0x0004.
- **Wrap:** TADDR_SPAN=0x200, DATA_BEATS=4; three packets with headers 0, 0x100, 0 -> no error, expected_taddr=0x100.
- **Clear and timeout:**
  - clear asserted together with a bad beat -> no error, counters 0.
  - Stop traffic with ACTIVE_TIMEOUT=10 -> eth_active falls exactly 10 cycles after the last beat.
